// File: rtl/crypto_block_sequencer.sv
// crypto_block_sequencer
// Adapter between a 32-bit valid/ready stream and a 128-bit block cipher
// engine. It packs up to four input words into one block, pulses the engine
// start, waits for the engine result, and streams the result back out as
// four 32-bit words. Only one block is in flight at a time.
//
// Optional feature macro: CRYPTO_SEQ_WDOG_EN
//   When defined, a WAIT-state watchdog aborts a block after TIMEOUT_CYCLES
//   and raises a sticky err_timeout. When undefined, err_timeout is tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast   32-bit input stream
//   m_tdata/m_tvalid/m_tready/m_tlast   32-bit output stream
//   eng_start, eng_din       one-cycle start pulse and 128-bit block to engine
//   eng_done, eng_dout       engine result valid and 128-bit result
//   blk_cnt                  completed-block counter, wraps modulo 2^CNT_W
//   err_timeout              sticky watchdog error
module crypto_block_sequencer #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             eng_start,
    output logic [127:0]     eng_din,
    input  logic             eng_done,
    input  logic [127:0]     eng_dout,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err_timeout
);

    typedef enum logic [1:0] {ST_PACK, ST_LAUNCH, ST_WAIT, ST_DRAIN} state_t;

    state_t             r_state;
    logic [1:0]         r_idx;       // word index, shared by PACK and DRAIN
    logic               r_last;      // current block ended the message
    logic               r_s_tready;
    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic [31:0]        r_m_tdata;
    logic               r_eng_start;
    logic [127:0]       r_blk;
    logic [95:0]        r_res;       // words 1..3 of the result; word 0 goes straight to m_tdata
    logic [CNT_W-1:0]   r_blk_cnt;

    logic               w_s_fire;
    logic               w_m_fire;
    logic [1:0]         w_idx_nxt;
    logic [127:0]       w_blk_ins;
    logic [31:0]        w_res_word;

    assign w_s_fire  = s_tvalid & r_s_tready;
    assign w_m_fire  = r_m_tvalid & m_tready;
    assign w_idx_nxt = r_idx + 2'd1;

    // Word k lands at bits [127-32k -: 32]; unreceived words stay zero.
    assign w_blk_ins = r_blk | ({s_tdata, 96'd0} >> {r_idx, 5'd0});

    // Next result word to present in DRAIN.
    always_comb begin
        case (w_idx_nxt)
            2'd1:    w_res_word = r_res[95:64];
            2'd2:    w_res_word = r_res[63:32];
            default: w_res_word = r_res[31:0];
        endcase
    end

`ifdef CRYPTO_SEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;
    logic            w_wd_expire;

    // r_wd_cnt holds (WAIT cycles elapsed - 1), so this fires on the last allowed cycle.
    assign w_wd_expire = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign err_timeout      = 1'b0;
`endif

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_PACK;
            r_idx         <= 2'd0;
            r_last        <= 1'b0;
            r_s_tready    <= 1'b0;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_m_tdata     <= 32'd0;
            r_eng_start   <= 1'b0;
            r_blk         <= 128'd0;
            r_res         <= 96'd0;
            r_blk_cnt     <= '0;
`ifdef CRYPTO_SEQ_WDOG_EN
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_eng_start <= 1'b0;
            case (r_state)
                ST_PACK: begin
                    r_s_tready <= 1'b1;
                    if (w_s_fire) begin
                        r_blk <= w_blk_ins;
                        if (r_idx == 2'd3 || s_tlast) begin
                            r_idx       <= 2'd0;
                            r_last      <= s_tlast;
                            r_s_tready  <= 1'b0;
                            r_eng_start <= 1'b1;
                            r_state     <= ST_LAUNCH;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end
                ST_LAUNCH: begin
`ifdef CRYPTO_SEQ_WDOG_EN
                    r_wd_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (eng_done) begin
                        r_res      <= eng_dout[95:0];
                        r_m_tdata  <= eng_dout[127:96];
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b0;
                        r_blk_cnt  <= r_blk_cnt + 1'b1;
                        r_idx      <= 2'd0;
                        r_state    <= ST_DRAIN;
                    end
`ifdef CRYPTO_SEQ_WDOG_EN
                    else if (w_wd_expire) begin
                        r_err_timeout <= 1'b1;
                        r_last        <= 1'b0;
                        r_blk         <= 128'd0;
                        r_s_tready    <= 1'b1;
                        r_state       <= ST_PACK;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (w_m_fire) begin
                        if (r_idx == 2'd3) begin
                            r_m_tvalid <= 1'b0;
                            r_m_tlast  <= 1'b0;
                            r_last     <= 1'b0;
                            r_blk      <= 128'd0;
                            r_idx      <= 2'd0;
                            r_s_tready <= 1'b1;
                            r_state    <= ST_PACK;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_m_tdata <= w_res_word;
                            r_m_tlast <= r_last & (w_idx_nxt == 2'd3);
                        end
                    end
                end
                default: r_state <= ST_PACK;
            endcase
        end
    end

    assign s_tready  = r_s_tready;
    assign m_tdata   = r_m_tdata;
    assign m_tvalid  = r_m_tvalid;
    assign m_tlast   = r_m_tlast;
    assign eng_start = r_eng_start;
    assign eng_din   = r_blk;
    assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_crypto_block_sequencer.sv
// Testbench for crypto_block_sequencer: table-driven directed blocks, hand
// sequences for back-pressure / reset / watchdog, and randomized messages
// checked against a word-grouping reference model and engine model.
module tb_crypto_block_sequencer;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TO_CYC = 16;

    typedef struct packed { logic [31:0] d; logic l; } word_t;
    typedef struct { logic [127:0] words; int n; logic [127:0] din; logic [127:0] dout; } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [31:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             eng_start;
    logic [127:0]     eng_din;
    logic             eng_done;
    logic [127:0]     eng_dout;
    logic [CNT_W-1:0] blk_cnt;
    logic             err_timeout;

    crypto_block_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .eng_start(eng_start), .eng_din(eng_din), .eng_done(eng_done), .eng_dout(eng_dout),
        .blk_cnt(blk_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    word_t        src_q[$];
    logic [127:0] exp_din_q[$];
    word_t        exp_out_q[$];
    int           grp_n = 0;
    int           out_j = 0;
    int           exp_cnt = 0;
    int           n_starts = 0;
    bit           eng_busy = 0;
    bit           eng_en = 1;
    bit           eng_noise = 0;
    bit           lat_rand = 0;
    bit           src_rand = 0;
    bit           rdy_rand = 0;
    int           eng_cnt = -1;
    int           eng_lat = 10;
    logic [127:0] eng_blk = '0;
    logic [127:0] eng_key = '1;
    vec_t         vecs[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Reference: split a word list into blocks (4 words or up to tlast), zero-pad,
    // and derive the expected engine input and output words.
    task automatic push_block(input logic [127:0] blk, input logic last);
        logic [127:0] r;
        exp_din_q.push_back(blk);
        r = blk ^ eng_key;
        for (int j = 0; j < 4; j++) begin
            word_t o;
            o.d = r[127-32*j -: 32];
            o.l = last && (j == 3);
            exp_out_q.push_back(o);
        end
    endtask

    task automatic add_msg(input int n);
        logic [127:0] blk;
        int k;
        blk = '0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.d = $urandom;
            w.l = (i == n - 1);
            src_q.push_back(w);
            blk[127-32*k -: 32] = w.d;
            k++;
            if (k == 4 || w.l) begin
                push_block(blk, w.l);
                blk = '0;
                k = 0;
            end
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            word_t w;
            w.d = v.words[127-32*k -: 32];
            w.l = (k == v.n - 1);
            src_q.push_back(w);
        end
        exp_din_q.push_back(v.din);
        for (int j = 0; j < 4; j++) begin
            word_t o;
            o.d = v.dout[127-32*j -: 32];
            o.l = (j == 3);
            exp_out_q.push_back(o);
        end
    endtask

    // One clock: drive inputs, predict handshakes, advance, check outputs.
    task automatic step();
        bit          s_fire, m_fire, stall, done_now, want_start, blk_end;
        logic [31:0] hold_d;
        logic        hold_l;
        if (src_q.size() != 0 && (!src_rand || $urandom_range(0, 3) != 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = src_q[0].d;
            s_tlast  = src_q[0].l;
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = $urandom;
            s_tlast  = 1'($urandom_range(0, 1));
        end
        if (rdy_rand) m_tready = 1'($urandom_range(0, 1));
        if (eng_busy && eng_en && eng_cnt == 0) begin
            eng_done = 1'b1;
            eng_dout = eng_blk ^ eng_key;
        end else begin
            eng_done = eng_noise && !eng_busy && ($urandom_range(0, 7) == 0);
            eng_dout = {$urandom, $urandom, $urandom, $urandom};
            if (eng_busy && eng_cnt > 0) eng_cnt--;
        end
        done_now   = eng_busy && eng_done;
        s_fire     = s_tvalid && s_tready;
        m_fire     = m_tvalid && m_tready;
        stall      = m_tvalid && !m_tready;
        hold_d     = m_tdata;
        hold_l     = m_tlast;
        want_start = 0;
        blk_end    = 0;
        if (eng_busy || m_tvalid) chk("s_tready_busy", 128'(s_tready), 128'd0);
        if (s_fire) begin
            void'(src_q.pop_front());
            grp_n++;
            if (grp_n == 4 || s_tlast) begin
                want_start = 1;
                grp_n = 0;
            end
        end
        if (m_fire) begin
            if (exp_out_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m_unexpected: got word %h, required no output", m_tdata);
            end else begin
                word_t e;
                e = exp_out_q.pop_front();
                chk("m_tdata", 128'(m_tdata), 128'(e.d));
                chk("m_tlast", 128'(m_tlast), 128'(e.l));
            end
            out_j++;
            if (out_j == 4) begin
                out_j = 0;
                blk_end = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("eng_start", 128'(eng_start), 128'(want_start));
        if (done_now) begin
            exp_cnt++;
            chk("m_tvalid_latency", 128'(m_tvalid), 128'd1);
            eng_busy = 0;
        end
        if (eng_start) begin
            n_starts++;
            if (exp_din_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL eng_start_unexpected: got din %h, required no start", eng_din);
            end else begin
                chk("eng_din", eng_din, exp_din_q.pop_front());
            end
            eng_busy = 1;
            eng_blk  = eng_din;
            eng_cnt  = lat_rand ? int'($urandom_range(1, 12)) : eng_lat;
        end
        chk("blk_cnt", 128'(blk_cnt), 128'(exp_cnt[CNT_W-1:0]));
        if (stall) begin
            chk("m_tvalid_hold", 128'(m_tvalid), 128'd1);
            chk("m_tdata_hold", 128'(m_tdata), 128'(hold_d));
            chk("m_tlast_hold", 128'(m_tlast), 128'(hold_l));
        end
        if (blk_end) begin
            chk("s_tready_after_drain", 128'(s_tready), 128'd1);
            chk("m_tvalid_after_drain", 128'(m_tvalid), 128'd0);
        end
    endtask

    task automatic run_idle(input string name);
        int n;
        n = 0;
        while ((src_q.size() != 0 || exp_out_q.size() != 0 || eng_busy || m_tvalid) && n < 3000) begin
            step();
            n++;
        end
        chk({name, "_complete"}, 128'(n < 3000 && exp_din_q.size() == 0), 128'd1);
    endtask

    // Reset with junk inputs, check cleared outputs, then one idle cycle.
    task automatic do_reset(input bit pulse_done);
        rst      = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        eng_done = 1'b1;
        eng_dout = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_m_tlast", 128'(m_tlast), 128'd0);
        chk("rst_m_tdata", 128'(m_tdata), 128'd0);
        chk("rst_eng_start", 128'(eng_start), 128'd0);
        chk("rst_eng_din", eng_din, 128'd0);
        chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("rst_err_timeout", 128'(err_timeout), 128'd0);
        src_q.delete();
        exp_din_q.delete();
        exp_out_q.delete();
        eng_busy = 0;
        eng_cnt  = -1;
        grp_n    = 0;
        out_j    = 0;
        exp_cnt  = 0;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        eng_done = pulse_done;
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        chk("s_tready_after_rst", 128'(s_tready), 128'd1);
        chk("m_tvalid_after_rst", 128'(m_tvalid), 128'd0);
        chk("blk_cnt_after_rst", 128'(blk_cnt), 128'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        vecs[0] = '{words: 128'h00112233_44556677_8899AABB_CCDDEEFF, n: 4,
                    din:   128'h00112233_44556677_8899AABB_CCDDEEFF,
                    dout:  128'hFFEEDDCC_BBAA9988_77665544_33221100};
        vecs[1] = '{words: 128'hDEADBEEF_01234567_00000000_00000000, n: 2,
                    din:   128'hDEADBEEF_01234567_00000000_00000000,
                    dout:  128'h21524110_FEDCBA98_FFFFFFFF_FFFFFFFF};
        vecs[2] = '{words: 128'hA5A5A5A5_00000000_00000000_00000000, n: 1,
                    din:   128'hA5A5A5A5_00000000_00000000_00000000,
                    dout:  128'h5A5A5A5A_FFFFFFFF_FFFFFFFF_FFFFFFFF};
        vecs[3] = '{words: 128'h11111111_22222222_33333333_00000000, n: 3,
                    din:   128'h11111111_22222222_33333333_00000000,
                    dout:  128'hEEEEEEEE_DDDDDDDD_CCCCCCCC_FFFFFFFF};

        do_reset(1'b0);

        // Directed table: full block, short blocks, tlast on word 0.
        m_tready = 1'b1;
        eng_key  = '1;
        for (int i = 0; i < 4; i++) begin
            push_vec(vecs[i]);
            run_idle("vec");
        end
        chk("blk_cnt_table", 128'(blk_cnt), 128'd4);

        // Back-pressure: 5 stalled cycles in DRAIN, then toggle ready.
        m_tready = 1'b0;
        push_vec(vecs[0]);
        n = 0;
        while (!m_tvalid && n < 200) begin
            step();
            n++;
        end
        chk("bp_reach_drain", 128'(m_tvalid), 128'd1);
        repeat (5) step();
        n = 0;
        while ((exp_out_q.size() != 0 || m_tvalid) && n < 200) begin
            m_tready = !m_tready;
            step();
            n++;
        end
        chk("bp_drained", 128'(exp_out_q.size() == 0 && n < 200), 128'd1);

        // Multi-block message: 12 words, tlast only on the last.
        eng_key  = {$urandom, $urandom, $urandom, $urandom};
        rdy_rand = 1;
        s0 = n_starts;
        add_msg(12);
        run_idle("multi");
        chk("multi_starts", 128'(n_starts - s0), 128'd3);

        // Randomized messages with gaps, random ready, latency and stray done.
        src_rand  = 1;
        lat_rand  = 1;
        eng_noise = 1;
        for (int i = 0; i < 20; i++) add_msg(int'($urandom_range(1, 9)));
        run_idle("random");
        src_rand  = 0;
        lat_rand  = 0;
        eng_noise = 0;
        rdy_rand  = 0;
        m_tready  = 1'b1;
        eng_key   = '1;

        // Reset three cycles into WAIT, then a stray done.
        s0 = n_starts;
        push_vec(vecs[0]);
        n = 0;
        while (n_starts == s0 && n < 200) begin
            step();
            n++;
        end
        chk("rstwait_started", 128'(n_starts - s0), 128'd1);
        repeat (3) step();
        do_reset(1'b1);
        push_vec(vecs[1]);
        run_idle("post_reset");

`ifdef CRYPTO_SEQ_WDOG_EN
        // Watchdog: engine never answers.
        eng_en = 0;
        s0 = n_starts;
        push_vec(vecs[2]);
        exp_out_q.delete();
        n = 0;
        while (n_starts == s0 && n < 200) begin
            step();
            n++;
        end
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 16) chk("wdog_not_yet", 128'(err_timeout), 128'd0);
        end
        eng_busy = 0;
        eng_cnt  = -1;
        chk("wdog_err", 128'(err_timeout), 128'd1);
        chk("wdog_back_to_pack", 128'(s_tready), 128'd1);
        chk("wdog_no_output", 128'(m_tvalid), 128'd0);
        eng_en = 1;
        push_vec(vecs[3]);
        run_idle("post_wdog");
        chk("wdog_sticky", 128'(err_timeout), 128'd1);
        do_reset(1'b0);
`else
        chk("err_timeout_off", 128'(err_timeout), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
